// File: rtl/qu_common_pkg.sv
// Shared types and constants for the qu core: reorder-buffer entry layout,
// ROB control states and default widths.
package qu_common;

  localparam int QU_ROB_DEPTH  = 16;
  localparam int QU_PREG_WIDTH = 6;
  localparam int QU_PC_WIDTH   = 32;
  localparam int QU_ARCH_WIDTH = 5;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } qu_rob_state_t;

  typedef struct packed {
    logic                     valid;
    logic                     done;
    logic                     exc;
    logic                     redir;
    logic [QU_PC_WIDTH-1:0]   pc;
    logic [QU_PC_WIDTH-1:0]   target;
    logic [QU_ARCH_WIDTH-1:0] rd_arch;
    logic [QU_PREG_WIDTH-1:0] rd_phys;
    logic [QU_PREG_WIDTH-1:0] rd_old_phys;
    logic                     rd_we;
  } qu_rob_entry_t;

endpackage

// File: rtl/qu_rob_ptr.sv
// Wrap-bit circular pointer for the reorder buffer: the MSB toggles each
// time the index wraps, so equal indices can be told apart as full or empty.
module qu_rob_ptr #(
  parameter int AW = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_inc,
  input  logic        i_clr,
  output logic [AW:0] o_ptr
);

  logic [AW:0] r_ptr;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= '0;
    end else if (i_clr) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= r_ptr + 1'b1;
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/qu_rob.sv
// In-order reorder buffer: allocates from rename, records completions,
// retires one uop per cycle and raises a one-cycle flush on redirect or
// exception. Define QU_ROB_STATS_EN to add retire/flush counters.
module qu_rob
  import qu_common::*;
#(
  parameter int ROB_DEPTH  = QU_ROB_DEPTH,
  parameter int PC_WIDTH   = QU_PC_WIDTH,
  parameter int PREG_WIDTH = QU_PREG_WIDTH,
  localparam int AW        = $clog2(ROB_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_valid,
  output logic                  alloc_ready,
  input  logic [PC_WIDTH-1:0]   alloc_pc,
  input  logic [4:0]            alloc_rd_arch,
  input  logic [PREG_WIDTH-1:0] alloc_rd_phys,
  input  logic [PREG_WIDTH-1:0] alloc_rd_old_phys,
  input  logic                  alloc_rd_we,
  output logic [AW-1:0]         alloc_tag,
  input  logic                  cmpl_valid,
  input  logic [AW-1:0]         cmpl_tag,
  input  logic                  cmpl_exception,
  input  logic                  cmpl_redirect,
  input  logic [PC_WIDTH-1:0]   cmpl_target,
  output logic                  retire_valid,
  output logic [4:0]            retire_rd_arch,
  output logic [PREG_WIDTH-1:0] retire_rd_phys,
  output logic                  retire_rd_we,
  output logic                  free_valid,
  output logic [PREG_WIDTH-1:0] free_phys,
  output logic                  flush,
  output logic                  branch,
  output logic                  exception,
  output logic [PC_WIDTH-1:0]   pc_override,
  output logic [AW:0]           count,
  output logic                  empty
`ifdef QU_ROB_STATS_EN
  ,
  output logic [31:0]           stat_retired,
  output logic [31:0]           stat_flushes
`endif
);

  qu_rob_entry_t r_rob [ROB_DEPTH];
  qu_rob_state_t r_state;
  logic                r_flush;
  logic                r_branch;
  logic                r_exception;
  logic [PC_WIDTH-1:0] r_pc_override;

  logic [AW:0]   w_head;
  logic [AW:0]   w_tail;
  logic          w_full;
  logic          w_alloc;
  logic          w_go_flush;
  logic          w_cmpl_ok;
  qu_rob_entry_t w_head_ent;
  logic          w_unused;

  qu_rob_ptr #(.AW(AW)) u_head (
    .clk   (clk),
    .rst   (rst),
    .i_inc (retire_valid),
    .i_clr (w_go_flush),
    .o_ptr (w_head)
  );

  qu_rob_ptr #(.AW(AW)) u_tail (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_alloc),
    .i_clr (w_go_flush),
    .o_ptr (w_tail)
  );

  assign w_full      = (w_head[AW-1:0] == w_tail[AW-1:0]) && (w_head[AW] != w_tail[AW]);
  assign alloc_ready = !w_full && (r_state == RUN);
  assign w_alloc     = alloc_valid && alloc_ready;
  assign alloc_tag   = w_tail[AW-1:0];
  assign count       = w_tail - w_head;
  assign empty       = (w_head == w_tail);

  assign w_head_ent   = r_rob[w_head[AW-1:0]];
  assign retire_valid = w_head_ent.valid && w_head_ent.done && (r_state == RUN);
  assign w_go_flush   = retire_valid && (w_head_ent.exc || w_head_ent.redir);
  assign w_cmpl_ok    = cmpl_valid && (r_state == RUN) && r_rob[cmpl_tag].valid;

  // An excepting uop never commits its new mapping, so that register is freed instead.
  assign retire_rd_arch = w_head_ent.rd_arch;
  assign retire_rd_phys = w_head_ent.rd_phys;
  assign retire_rd_we   = retire_valid && w_head_ent.rd_we && !w_head_ent.exc;
  assign free_valid     = retire_valid && w_head_ent.rd_we;
  assign free_phys      = w_head_ent.exc ? w_head_ent.rd_phys : w_head_ent.rd_old_phys;

  // NOTE: only the valid/done bits are reset; payload fields are always
  // rewritten on allocation, so the storage needs no reset network.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        r_rob[i].valid <= 1'b0;
        r_rob[i].done  <= 1'b0;
      end
    end else if (w_go_flush) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        r_rob[i].valid <= 1'b0;
      end
    end else begin
      if (w_cmpl_ok) begin
        r_rob[cmpl_tag].done   <= 1'b1;
        r_rob[cmpl_tag].exc    <= cmpl_exception;
        r_rob[cmpl_tag].redir  <= cmpl_redirect;
        r_rob[cmpl_tag].target <= cmpl_target;
      end
      if (retire_valid) begin
        r_rob[w_head[AW-1:0]].valid <= 1'b0;
      end
      if (w_alloc) begin
        r_rob[w_tail[AW-1:0]].valid       <= 1'b1;
        r_rob[w_tail[AW-1:0]].done        <= 1'b0;
        r_rob[w_tail[AW-1:0]].exc         <= 1'b0;
        r_rob[w_tail[AW-1:0]].redir       <= 1'b0;
        r_rob[w_tail[AW-1:0]].pc          <= alloc_pc;
        r_rob[w_tail[AW-1:0]].rd_arch     <= alloc_rd_arch;
        r_rob[w_tail[AW-1:0]].rd_phys     <= alloc_rd_phys;
        r_rob[w_tail[AW-1:0]].rd_old_phys <= alloc_rd_old_phys;
        r_rob[w_tail[AW-1:0]].rd_we       <= alloc_rd_we;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= RUN;
      r_flush       <= 1'b0;
      r_branch      <= 1'b0;
      r_exception   <= 1'b0;
      r_pc_override <= '0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_go_flush) begin
            r_state       <= FLUSH;
            r_flush       <= 1'b1;
            r_branch      <= w_head_ent.redir && !w_head_ent.exc;
            r_exception   <= w_head_ent.exc;
            r_pc_override <= w_head_ent.target;
          end
        end
        FLUSH: begin
          r_state       <= RUN;
          r_flush       <= 1'b0;
          r_branch      <= 1'b0;
          r_exception   <= 1'b0;
          r_pc_override <= '0;
        end
        default: r_state <= RUN;
      endcase
    end
  end

  assign flush       = r_flush;
  assign branch      = r_branch;
  assign exception   = r_exception;
  assign pc_override = r_pc_override;

`ifdef QU_ROB_STATS_EN
  logic [31:0] r_stat_retired;
  logic [31:0] r_stat_flushes;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stat_retired <= '0;
      r_stat_flushes <= '0;
    end else begin
      if (retire_valid) r_stat_retired <= r_stat_retired + 32'd1;
      if (w_go_flush)   r_stat_flushes <= r_stat_flushes + 32'd1;
    end
  end

  assign stat_retired = r_stat_retired;
  assign stat_flushes = r_stat_flushes;
`endif

  // The uop PC is kept for debug visibility but drives no output.
  assign w_unused = ^w_head_ent.pc;

endmodule

// File: tb/tb_qu_rob.sv
// Bench for qu_rob: directed scenarios plus random traffic, checked every
// cycle against a queue-based program-order model of the ROB.
module tb_qu_rob;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        alloc_valid = 1'b0;
  logic        alloc_ready;
  logic [31:0] alloc_pc = '0;
  logic [4:0]  alloc_rd_arch = '0;
  logic [5:0]  alloc_rd_phys = '0;
  logic [5:0]  alloc_rd_old_phys = '0;
  logic        alloc_rd_we = 1'b0;
  logic [3:0]  alloc_tag;
  logic        cmpl_valid = 1'b0;
  logic [3:0]  cmpl_tag = '0;
  logic        cmpl_exception = 1'b0;
  logic        cmpl_redirect = 1'b0;
  logic [31:0] cmpl_target = '0;
  logic        retire_valid;
  logic [4:0]  retire_rd_arch;
  logic [5:0]  retire_rd_phys;
  logic        retire_rd_we;
  logic        free_valid;
  logic [5:0]  free_phys;
  logic        flush;
  logic        branch;
  logic        exception;
  logic [31:0] pc_override;
  logic [4:0]  count;
  logic        empty;

  qu_rob dut (
    .clk               (clk),
    .rst               (rst),
    .alloc_valid       (alloc_valid),
    .alloc_ready       (alloc_ready),
    .alloc_pc          (alloc_pc),
    .alloc_rd_arch     (alloc_rd_arch),
    .alloc_rd_phys     (alloc_rd_phys),
    .alloc_rd_old_phys (alloc_rd_old_phys),
    .alloc_rd_we       (alloc_rd_we),
    .alloc_tag         (alloc_tag),
    .cmpl_valid        (cmpl_valid),
    .cmpl_tag          (cmpl_tag),
    .cmpl_exception    (cmpl_exception),
    .cmpl_redirect     (cmpl_redirect),
    .cmpl_target       (cmpl_target),
    .retire_valid      (retire_valid),
    .retire_rd_arch    (retire_rd_arch),
    .retire_rd_phys    (retire_rd_phys),
    .retire_rd_we      (retire_rd_we),
    .free_valid        (free_valid),
    .free_phys         (free_phys),
    .flush             (flush),
    .branch            (branch),
    .exception         (exception),
    .pc_override       (pc_override),
    .count             (count),
    .empty             (empty)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Program-order model: q[0] is the oldest live uop.
  typedef struct {
    int          tag;
    logic [4:0]  arch;
    logic [5:0]  phys;
    logic [5:0]  old;
    bit          we;
    bit          done;
    bit          exc;
    bit          redir;
    logic [31:0] target;
  } ment_t;

  ment_t       q[$];
  int          m_next_tag = 0;
  bit          m_flush = 0;
  bit          m_br = 0;
  bit          m_ex = 0;
  logic [31:0] m_pc = '0;

  task automatic model_reset();
    q.delete();
    m_next_tag = 0;
    m_flush = 0;
    m_br = 0;
    m_ex = 0;
    m_pc = '0;
  endtask

  // Called at a falling edge: check outputs, drive inputs, advance one cycle.
  task automatic step(input bit av, input logic [31:0] pc, input logic [4:0] arch,
                      input logic [5:0] phys, input logic [5:0] old, input bit we,
                      input bit cv, input logic [3:0] ctag, input bit cexc,
                      input bit credir, input logic [31:0] ctgt);
    int    n;
    bit    exp_rv;
    bit    ready;
    bit    flushing;
    ment_t h;
    ment_t e;
    n = q.size();
    ready = (n < 16) && !m_flush;
    exp_rv = !m_flush && (n > 0) && q[0].done;
    check("count", count, n);
    check("empty", empty, n == 0);
    check("alloc_ready", alloc_ready, ready);
    check("alloc_tag", alloc_tag, m_next_tag);
    check("retire_valid", retire_valid, exp_rv);
    if (exp_rv) begin
      h = q[0];
      check("retire_rd_arch", retire_rd_arch, h.arch);
      check("retire_rd_phys", retire_rd_phys, h.phys);
      check("retire_rd_we", retire_rd_we, h.we && !h.exc);
      check("free_valid", free_valid, h.we);
      check("free_phys", free_phys, h.exc ? h.phys : h.old);
    end
    check("flush", flush, m_flush);
    check("branch", branch, m_flush && m_br);
    check("exception", exception, m_flush && m_ex);
    check("pc_override", pc_override, m_flush ? m_pc : 32'h0);

    alloc_valid = av; alloc_pc = pc; alloc_rd_arch = arch;
    alloc_rd_phys = phys; alloc_rd_old_phys = old; alloc_rd_we = we;
    cmpl_valid = cv; cmpl_tag = ctag; cmpl_exception = cexc;
    cmpl_redirect = credir; cmpl_target = ctgt;
    @(posedge clk);

    if (m_flush) begin
      m_flush = 0;
      m_br = 0;
      m_ex = 0;
      m_pc = '0;
    end else begin
      flushing = 0;
      if (cv) begin
        foreach (q[i]) begin
          if (q[i].tag == int'(ctag)) begin
            q[i].done = 1; q[i].exc = cexc; q[i].redir = credir; q[i].target = ctgt;
          end
        end
      end
      if (exp_rv) begin
        void'(q.pop_front());
        if (h.exc || h.redir) begin
          flushing = 1;
          q.delete();
          m_next_tag = 0;
          m_flush = 1;
          m_br = h.redir && !h.exc;
          m_ex = h.exc;
          m_pc = h.target;
        end
      end
      if (!flushing && av && ready) begin
        e.tag = m_next_tag; e.arch = arch; e.phys = phys; e.old = old; e.we = we;
        e.done = 0; e.exc = 0; e.redir = 0; e.target = '0;
        q.push_back(e);
        m_next_tag = (m_next_tag + 1) % 16;
      end
    end
    @(negedge clk);
    alloc_valid = 1'b0;
    cmpl_valid = 1'b0;
  endtask

  task automatic idle();
    step(0, '0, '0, '0, '0, 0, 0, '0, 0, 0, '0);
  endtask

  task automatic alloc(input logic [31:0] pc, input logic [4:0] arch, input logic [5:0] phys,
                       input logic [5:0] old, input bit we);
    step(1, pc, arch, phys, old, we, 0, '0, 0, 0, '0);
  endtask

  task automatic cmpl(input logic [3:0] tag, input bit exc, input bit redir, input logic [31:0] tgt);
    step(0, '0, '0, '0, '0, 0, 1, tag, exc, redir, tgt);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_empty", empty, 1'b1);
    check("rst_count", count, 5'd0);
    check("rst_alloc_ready", alloc_ready, 1'b1);
    check("rst_retire_valid", retire_valid, 1'b0);
    check("rst_flush", flush, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  initial begin
    // Reset behaviour.
    @(negedge clk);
    do_reset();

    // In-order retire with out-of-order completion.
    alloc(32'h100, 5'd1, 6'd33, 6'd1, 1);
    alloc(32'h104, 5'd2, 6'd34, 6'd2, 1);
    alloc(32'h108, 5'd3, 6'd35, 6'd3, 1);
    cmpl(4'd2, 0, 0, '0);
    check("order_no_retire_yet", retire_valid, 1'b0);
    cmpl(4'd0, 0, 0, '0);
    check("order_rv0", retire_valid, 1'b1);
    check("order_phys0", retire_rd_phys, 6'd33);
    cmpl(4'd1, 0, 0, '0);
    check("order_phys1", retire_rd_phys, 6'd34);
    idle();
    check("order_phys2", retire_rd_phys, 6'd35);
    idle();
    check("order_drained", empty, 1'b1);

    // Full and wrap.
    do_reset();
    for (int i = 0; i < 16; i++) alloc(32'h1000 + 4 * i, 5'(i), 6'(i + 16), 6'(i), 1);
    check("full_ready", alloc_ready, 1'b0);
    check("full_count", count, 5'd16);
    step(1, 32'h2000, 5'd9, 6'd9, 6'd9, 1, 1, 4'd0, 0, 0, '0);
    check("full_rv", retire_valid, 1'b1);
    check("full_still_full", alloc_ready, 1'b0);
    idle();
    check("wrap_ready", alloc_ready, 1'b1);
    check("wrap_tag", alloc_tag, 4'd0);
    alloc(32'h3000, 5'd4, 6'd50, 6'd5, 1);
    check("wrap_count", count, 5'd16);

    // Redirect.
    do_reset();
    for (int i = 0; i < 3; i++) alloc(32'h100 + 4 * i, 5'(i + 1), 6'(i + 33), 6'(i + 1), 1);
    cmpl(4'd0, 0, 0, '0);
    cmpl(4'd1, 0, 1, 32'h200);
    idle();
    check("redir_flush", flush, 1'b1);
    check("redir_branch", branch, 1'b1);
    check("redir_pc", pc_override, 32'h200);
    idle();
    check("redir_flush_off", flush, 1'b0);
    check("redir_count", count, 5'd0);

    // Exception.
    do_reset();
    alloc(32'h400, 5'd7, 6'd40, 6'd12, 1);
    cmpl(4'd0, 1, 0, 32'h800);
    check("exc_rd_we", retire_rd_we, 1'b0);
    check("exc_free_phys", free_phys, 6'd40);
    idle();
    check("exc_exception", exception, 1'b1);
    check("exc_branch", branch, 1'b0);
    idle();
    check("exc_exception_off", exception, 1'b0);

    // Mid-operation reset between edges.
    do_reset();
    for (int i = 0; i < 5; i++) alloc(32'h500 + 4 * i, 5'(i), 6'(i + 20), 6'(i), 1);
    cmpl(4'd0, 0, 0, '0);
    #2 rst = 1'b0;
    #1;
    check("midrst_empty", empty, 1'b1);
    check("midrst_count", count, 5'd0);
    check("midrst_rv", retire_valid, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) idle();

    // Random traffic.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      bit         av;
      bit         cv;
      logic [3:0] ct;
      av = ($urandom % 3) != 0;
      cv = ($urandom % 2) == 0;
      if (q.size() > 0 && ($urandom % 4) != 0) ct = 4'(q[$urandom_range(0, q.size() - 1)].tag);
      else ct = 4'($urandom % 16);
      step(av, $urandom, 5'($urandom), 6'($urandom), 6'($urandom), 1'($urandom),
           cv, ct, ($urandom % 16) == 0, ($urandom % 8) == 0, $urandom);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/qu_rob.md
QU_ROB -- requirements
Module: qu_rob

Interface
REQ-001 SHALL have parameter ROB_DEPTH, default 16, the number of entries (power of two, at least 4).
REQ-002 SHALL have parameter PC_WIDTH, default QU_PC_WIDTH, the instruction address width.
REQ-003 SHALL have parameter PREG_WIDTH, default 6, the physical register index width; architectural index width is fixed at 5.
REQ-004 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have ports alloc_valid/alloc_ready  input/output  1  the allocation handshake from rename.
REQ-007 SHALL have ports alloc_pc (PC_WIDTH), alloc_rd_arch (5), alloc_rd_phys (PREG_WIDTH), alloc_rd_old_phys (PREG_WIDTH) and alloc_rd_we (1), all inputs, describing the allocated uop.
REQ-008 SHALL have port alloc_tag  output  log2(ROB_DEPTH)  the slot index assigned to the current allocation.
REQ-009 SHALL have completion input ports cmpl_valid (1), cmpl_tag (log2 ROB_DEPTH), cmpl_exception (1), cmpl_redirect (1) and cmpl_target (PC_WIDTH).
REQ-010 SHALL have retire output ports retire_valid (1), retire_rd_arch (5), retire_rd_phys (PREG_WIDTH), retire_rd_we (1), free_valid (1) and free_phys (PREG_WIDTH).
REQ-011 SHALL have redirect output ports flush (1), branch (1), exception (1) and pc_override (PC_WIDTH), which drive the core front end.
REQ-012 SHALL have status output ports count (log2(ROB_DEPTH)+1) and empty (1).

Function
REQ-013 SHALL be a circular buffer with head and tail pointers, each carrying an extra wrap bit; full is equal indices with differing wrap bits.
REQ-014 SHALL drive alloc_ready = !full && state==RUN, using the pre-retire occupancy, with no same-cycle bypass when full.
REQ-015 SHALL, on alloc_valid && alloc_ready, write the slot at tail with valid=1, done=0, flags clear, advance tail, and drive alloc_tag = tail index combinationally.
REQ-016 SHALL, on cmpl_valid for a valid slot, set done and record exception/redirect/target; a completion to an invalid slot, or any completion in FLUSH, SHALL be ignored.
REQ-017 SHALL drive retire_valid combinationally, equal to head.valid && head.done && state==RUN; the head advances on that edge, so at most one uop retires per cycle in program order.
REQ-018 SHALL, on a normal retire, present retire_rd_we=rd_we, free_valid=rd_we, free_phys=old_phys.
REQ-019 SHALL, on an exception retire, force retire_rd_we=0, free_valid=rd_we and free_phys=rd_phys (the new mapping is discarded).
REQ-020 SHALL implement FSM states RUN and FLUSH; a retire with a redirect or exception flag moves RUN to FLUSH, and FLUSH always returns to RUN after one cycle.
REQ-021 SHALL, on that transition edge, clear all valid bits and zero head and tail, so all younger entries are discarded.
REQ-022 SHALL register flush, pc_override=target and branch=redirect && !exception (else exception=1), high for exactly the FLUSH cycle; each is 0 otherwise.
REQ-023 SHALL treat a completion that marks the head done as retirable in the next cycle, never in the same cycle.
REQ-024 SHALL let allocation and retire in the same cycle leave count unchanged; count and empty are combinational from the pointers.

Reset
REQ-025 SHALL, while rst=0, immediately clear all valid and done bits, zero head and tail, set state to RUN, and drive flush, branch, exception and pc_override to 0.
REQ-026 SHALL give reset precedence over every in-flight allocate, complete or flush, with no partial state surviving.

Configuration
REQ-027 SHALL, with QU_ROB_STATS_EN defined, add 32-bit outputs stat_retired and stat_flushes, which count retires and FLUSH entries, wrap modulo 2^32 and reset to 0.
REQ-028 SHALL, without QU_ROB_STATS_EN, omit those ports and counters entirely.

Structure
REQ-029 SHALL take qu_rob_entry_t (valid, done, exc, redir, pc, target, rd fields) and qu_rob_state_t {RUN, FLUSH} from package qu_common.
REQ-030 SHALL take QU_ROB_DEPTH and QU_PREG_WIDTH constants from package qu_common.
REQ-031 SHALL implement the wrap-bit pointer in a sub-module qu_rob_ptr (increment, clear), instanced for head and tail.

Verification
REQ-032 Reset: drive rst=0 -> empty=1, count=0, alloc_ready=1, retire_valid=0, flush=0.
REQ-033 In-order retire: alloc pc 0x100/0x104/0x108 (phys 33/34/35), complete tags 2,0,1 -> retire tags 0,1,2 on consecutive cycles with retire_rd_phys 33,34,35.
REQ-034 Full and wrap: allocate 16 -> alloc_ready=0, count=16; complete tag 0 -> retire, then alloc_ready=1 next cycle and the new alloc_tag=0.
REQ-035 Redirect: tags 0,1,2 valid; complete 0, and 1 with redirect target 0x200 -> 0 and 1 retire, then one cycle of flush=1, branch=1, pc_override=0x200, then count=0.
REQ-036 Exception: head rd_we=1, phys 40, old 12, exception -> retire_rd_we=0, free_phys=40, exception=1 for one cycle.
REQ-037 Mid-operation reset: with 5 entries held, drive rst=0 between edges -> empty=1 immediately, with no retire_valid after release.
